stopwatch_display: RTL and testbench
====================================

# stopwatch_display

Display-side consumer of the stopwatch counter outputs. It samples `minutes`, `seconds` and `status` and converts them to BCD with a sequential shift-add-3 (double-dabble) engine. It then drives a 5-digit multiplexed, common-anode 7-segment display showing MMM.SS. Paused time blinks, invalid status shows dashes, and out-of-range inputs are flagged. It sits between the stopwatch counters and the board pins.

## Interface
- `SCAN_DIV`, default 4: clk cycles each digit stays enabled; range 1–65535.
- `BLINK_DIV`, default 64: clk cycles per blink half-period; range 1–2^24-1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `minutes`  in  8  minute count, nominally 0–120.
- `seconds`  in  6  second count, nominally 0–59.
- `status`  in  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 invalid.
- `an`  out  5  digit enables, active-low, one-hot. an[0] = seconds units, an[4] = minutes hundreds.
- `seg`  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- `dp`  out  1  decimal point, active-low.
- `range_err`  out  1  high when the last committed frame had minutes>120 or seconds>59.
- `frame_done`  out  1  single-cycle pulse in the COMMIT cycle.

## Operation
- Conversion FSM runs continuously with no idle state: LOAD → CONV_MIN (8 cycles) → CONV_SEC (6 cycles) → COMMIT → LOAD. One frame is 16 cycles.
- LOAD:
  - Snapshot minutes, seconds and status into shadow registers.
  - Clear the BCD scratch registers (12-bit minutes, 8-bit seconds).
- CONV_MIN / CONV_SEC: each cycle, add 3 to every BCD nibble ≥5, then shift in the next MSB of the shadow value.
- COMMIT:
  - Copy the 5 BCD digits and shadow status into the display registers.
  - Update `range_err` from the shadow values.
  - Pulse `frame_done`.
- Full 8-bit and 6-bit input ranges convert correctly: 255 → 2,5,5; 63 → 6,3. Out-of-range values are displayed as-is, never clamped.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances 0→1→2→3→4→0.
- Blink phase:
  - Free-runs regardless of status.
  - Toggles every BLINK_DIV cycles.
  - Reset value is 1 (visible).
- Per-digit output (`an`, `seg`, `dp` registered, from the committed display registers):
  - `an` = ~(1<<index).
  - `seg` codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, dash=7'h3F, blank=7'h7F.
  - `dp` = 0 only when index==2 (separator after minutes units), otherwise 1.
- Status handling:
  - IDLE / RUNNING: normal digits.
  - PAUSED with blink phase 0: `an`=5'b11111, seg=7'h7F, dp=1. PAUSED with phase 1: normal.
  - 11: every digit shows dash, dp=1.
- Leading-zero blanking:
  - Digit 4 shows blank when the minutes hundreds digit is 0.
  - Digit 3 shows blank when the hundreds and tens digits are both 0.
  - Never applies under status 11.
- Reset (async, any time, including mid-frame):
  - FSM returns to LOAD; scratch, shadow and display registers clear to 0 / status 00.
  - Scan counter, index and blink counter clear to 0; blink phase 1.
  - Outputs: an=5'b11111, seg=7'h7F, dp=1, range_err=0, frame_done=0.
  - The partial frame is discarded; there is no partial commit.

## Timing
- After `rst` deasserts:
  - First edge: FSM in LOAD; an=5'b11110, seg=7'h40 (committed value 0).
  - First COMMIT on the 16th edge; `frame_done` is high in that cycle.
- Input → display latency: the value present at the LOAD edge reaches the display registers 15 cycles later. Worst case from an input change is 31 cycles.
- Inputs changing during CONV_MIN, CONV_SEC or COMMIT do not affect the current frame.
- `an`, `seg` and `dp` change 1 cycle after the index or blink phase changes. `an` is never multi-hot.
- With SCAN_DIV=1 the index advances every cycle.
- A status change takes effect at COMMIT, not at LOAD.

## Test plan
- Reset, then hold minutes=0, seconds=0, status=00 → frame_done every 16 cycles. Digit sequence:
  - an[0] and an[1]: 7'h40.
  - an[2]: 7'h40 with dp=0.
  - an[3] and an[4]: 7'h7F.
- minutes=120, seconds=59, status=01 → digits 4..0 show 1,2,0,5,9 (7'h79, 7'h24, 7'h40, 7'h12, 7'h10); range_err=0.
- minutes=255, seconds=63 → digits show 2,5,5,6,3; range_err=1 at the first COMMIT. Then set 5/7 → range_err=0 and digits blank,blank,5,0,7 after the next COMMIT.
- status=10, BLINK_DIV=8 → an=5'b11111 for 8 cycles, then normal scanning for 8 cycles, repeating. status=11 → all digits 7'h3F.
- Change seconds 10→11 mid-CONV_SEC → current frame commits 10, next frame commits 11; measured latency ≤31 cycles.
- Assert rst at CONV_MIN cycle 4 with committed value 7:30 → outputs go to reset values immediately (an=11111, seg=7'h7F); after release the first frame commits the fresh sample.

Source files
------------

// File: rtl/stopwatch_display.sv
// Stopwatch display driver: samples minutes/seconds/status, converts them to BCD with a
// sequential double-dabble engine, and scans a 5-digit common-anode 7-segment display (MMM.SS).
module stopwatch_display #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] status,
    output logic [4:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       range_err,
    output logic       frame_done
);

    // state    | meaning
    // LOAD     | snapshot inputs, clear BCD scratch
    // CONV_MIN | 8 add-3/shift steps on minutes
    // CONV_SEC | 6 add-3/shift steps on seconds
    // COMMIT   | publish digits/status to display registers
    typedef enum logic [1:0] {LOAD, CONV_MIN, CONV_SEC, COMMIT} state_t;

    localparam logic [1:0] ST_PAUSED  = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt;
    logic [7:0]  sh_min, wk_min;
    logic [5:0]  sh_sec, wk_sec;
    logic [1:0]  sh_status;
    logic [11:0] bcd_min, min_adj;
    logic [7:0]  bcd_sec, sec_adj;
    logic [3:0]  d_min_h, d_min_t, d_min_u, d_sec_t, d_sec_u;
    logic [1:0]  d_status;

    logic [15:0] scan_cnt;
    logic [2:0]  idx;
    logic [23:0] blink_cnt;
    logic        phase;

    logic [3:0]  dig;
    logic        lz_blank;
    logic [4:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    function automatic logic [3:0] nib_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign min_adj    = {nib_adj(bcd_min[11:8]), nib_adj(bcd_min[7:4]), nib_adj(bcd_min[3:0])};
    assign sec_adj    = {nib_adj(bcd_sec[7:4]), nib_adj(bcd_sec[3:0])};
    assign frame_done = (state == COMMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:     state_nxt = CONV_MIN;
            CONV_MIN: if (bit_cnt == 3'd7) state_nxt = CONV_SEC;
            CONV_SEC: if (bit_cnt == 3'd5) state_nxt = COMMIT;
            COMMIT:   state_nxt = LOAD;
            default:  state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            sh_min    <= '0;
            wk_min    <= '0;
            sh_sec    <= '0;
            wk_sec    <= '0;
            sh_status <= '0;
            bcd_min   <= '0;
            bcd_sec   <= '0;
            d_min_h   <= '0;
            d_min_t   <= '0;
            d_min_u   <= '0;
            d_sec_t   <= '0;
            d_sec_u   <= '0;
            d_status  <= '0;
            range_err <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    sh_min    <= minutes;
                    wk_min    <= minutes;
                    sh_sec    <= seconds;
                    wk_sec    <= seconds;
                    sh_status <= status;
                    bcd_min   <= '0;
                    bcd_sec   <= '0;
                    bit_cnt   <= '0;
                end
                CONV_MIN: begin
                    // The working copy shifts out MSB-first into the adjusted scratch.
                    {bcd_min, wk_min} <= {min_adj, wk_min} << 1;
                    bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
                end
                CONV_SEC: begin
                    {bcd_sec, wk_sec} <= {sec_adj, wk_sec} << 1;
                    bit_cnt <= (bit_cnt == 3'd5) ? 3'd0 : bit_cnt + 3'd1;
                end
                COMMIT: begin
                    d_min_h   <= bcd_min[11:8];
                    d_min_t   <= bcd_min[7:4];
                    d_min_u   <= bcd_min[3:0];
                    d_sec_t   <= bcd_sec[7:4];
                    d_sec_u   <= bcd_sec[3:0];
                    d_status  <= sh_status;
                    range_err <= (sh_min > 8'd120) || (sh_sec > 6'd59);
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            if (scan_cnt == 16'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
            if (blink_cnt == 24'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 24'd1;
            end
        end
    end

    always_comb begin
        dig      = 4'd0;
        lz_blank = 1'b0;
        case (idx)
            3'd0: dig = d_sec_u;
            3'd1: dig = d_sec_t;
            3'd2: dig = d_min_u;
            3'd3: begin
                dig      = d_min_t;
                lz_blank = (d_min_h == 4'd0) && (d_min_t == 4'd0);
            end
            3'd4: begin
                dig      = d_min_h;
                lz_blank = (d_min_h == 4'd0);
            end
            default: dig = 4'd0;
        endcase

        an_nxt  = ~(5'(1) << idx);
        dp_nxt  = !((idx == 3'd2) && (d_status != ST_INVALID));
        if (d_status == ST_INVALID) seg_nxt = 7'h3F;
        else if (lz_blank)          seg_nxt = 7'h7F;
        else                        seg_nxt = seg7(dig);

        if ((d_status == ST_PAUSED) && !phase) begin
            an_nxt  = 5'b11111;
            seg_nxt = 7'h7F;
            dp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 5'b11111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display: a cycle counter since reset release drives a
// small scan/blink/frame model that supplies the expected an/seg/dp/frame_done values.
module tb_stopwatch_display;

    localparam int SCAN  = 2;
    localparam int BLINK = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic [4:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       range_err;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    int cyc;

    stopwatch_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk        (clk),
        .rst        (rst),
        .minutes    (minutes),
        .seconds    (seconds),
        .status     (status),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .range_err  (range_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Rising edges seen since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ends on the negedge where frame_done is high; that must be cyc%16==15.
    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_done !== 1'b1 && k < 40);
        chk("frame_done_seen", 32'(frame_done), 32'd1);
        chk("frame_phase", 32'(cyc % 16), 32'd15);
    endtask

    // Let two commits pass so the current inputs are on display, then step past the commit edge.
    task automatic settle();
        wait_frame();
        wait_frame();
        tick(2);
    endtask

    // mode 0 normal, 1 paused (blinking), 2 invalid (dashes, no dp)
    task automatic check_digits(input logic [6:0] e4, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0,
                                input int mode, input int n, input string tag);
        logic [6:0] tbl [0:4];
        logic [4:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int         ix;
        tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3; tbl[4] = e4;
        for (int i = 0; i < n; i++) begin
            ix = ((cyc - 1) / SCAN) % 5;
            if (mode == 1 && (((cyc - 1) / BLINK) % 2) == 1) begin
                exp_an  = 5'b11111;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_an  = ~(5'(1) << ix);
                exp_seg = tbl[ix];
                exp_dp  = (mode != 2 && ix == 2) ? 1'b0 : 1'b1;
            end
            chk({tag, "_an"}, 32'(an), 32'(exp_an));
            chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
            chk({tag, "_dp"}, 32'(dp), 32'(exp_dp));
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; minutes = 8'd0; seconds = 6'd0; status = 2'b00;
        tick(2);
        chk("rst_an", 32'(an), 32'h1F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        rst = 1'b0;
        tick(1);
        chk("first_an", 32'(an), 32'h1E);
        chk("first_seg", 32'(seg), 32'h40);
        chk("first_frame_done", 32'(frame_done), 32'd0);
        tick(13);
        chk("fd_cyc14", 32'(frame_done), 32'd0);
        tick(1);
        chk("fd_cyc15", 32'(frame_done), 32'd1);
        tick(1);
        chk("fd_cyc16", 32'(frame_done), 32'd0);
        tick(1);
        check_digits(7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 0, 10, "zero");

        minutes = 8'd120; seconds = 6'd59; status = 2'b01;
        settle();
        chk("range_120_59", 32'(range_err), 32'd0);
        check_digits(7'h79, 7'h24, 7'h40, 7'h12, 7'h10, 0, 10, "d120_59");

        minutes = 8'd255; seconds = 6'd63;
        settle();
        chk("range_255_63", 32'(range_err), 32'd1);
        check_digits(7'h24, 7'h12, 7'h12, 7'h02, 7'h30, 0, 10, "d255_63");

        minutes = 8'd5; seconds = 6'd7;
        settle();
        chk("range_5_7", 32'(range_err), 32'd0);
        check_digits(7'h7F, 7'h7F, 7'h12, 7'h40, 7'h78, 0, 10, "d5_07");

        status = 2'b10;
        settle();
        check_digits(7'h7F, 7'h7F, 7'h12, 7'h40, 7'h78, 1, 20, "paused");

        status = 2'b11;
        settle();
        check_digits(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 2, 10, "invalid");

        // Seconds change in the middle of CONV_SEC must not disturb the frame in flight.
        status = 2'b01; minutes = 8'd0; seconds = 6'd10;
        settle();
        tick(11);
        chk("mid_conv_sec_phase", 32'(cyc % 16), 32'd12);
        seconds = 6'd11;
        wait_frame();
        tick(2);
        check_digits(7'h7F, 7'h7F, 7'h40, 7'h79, 7'h40, 0, 10, "s10_kept");
        wait_frame();
        tick(2);
        check_digits(7'h7F, 7'h7F, 7'h40, 7'h79, 7'h79, 0, 10, "s11_next");

        // Reset during CONV_MIN step 4 with 7:30 on display.
        minutes = 8'd7; seconds = 6'd30;
        settle();
        check_digits(7'h7F, 7'h7F, 7'h78, 7'h30, 7'h40, 0, 10, "d7_30");
        wait_frame();
        tick(6);
        minutes = 8'd42; seconds = 6'd17; status = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk("midrst_an", 32'(an), 32'h1F);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_dp", 32'(dp), 32'd1);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        chk("post_rst_an", 32'(an), 32'h1E);
        chk("post_rst_seg", 32'(seg), 32'h40);
        tick(15);
        chk("post_rst_old_seg", 32'(seg), 32'h40);
        chk("post_rst_old_dp", 32'(dp), 32'd0);
        tick(1);
        check_digits(7'h7F, 7'h19, 7'h24, 7'h79, 7'h78, 0, 10, "d42_17");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
